// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiplier sequencer/arbiter.
// Contents: FSM state enum, operand/product widths, default operand hold length.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } state_e;

  localparam int unsigned OPW             = 5;  // operand width
  localparam int unsigned PW              = 9;  // product width
  localparam int unsigned HOLD_CYCLES_DEF = 6;  // 5 sampling rows + final adder register

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> N-1, so index 0 wins first)
//   req       - request vector
//   advance   - move the pointer to the current grant_id (accepted handshake)
//   grant     - one-hot combinational grant, zero when no request
//   grant_id  - encoded index of grant
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  logic [IW-1:0] last_q, last_d;
  logic          found;

  // Two passes: indices above the pointer first, then wrap to 0..pointer.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(last_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(last_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = IW'(i);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) begin
      last_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mul_seq_arb.sv
// Sequencer + round-robin arbiter sharing one 5x5 signed multiplier among NREQ requesters.
// One operation at a time: operands are held stable for HOLD_CYCLES plus one sample cycle,
// then the product is captured and returned with the requester ID.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (req_ready one-hot, IDLE only)
//   req_a, req_b          - packed signed operands, requester i at [i*5 +: 5]
//   mul_a, mul_b, mul_en  - operand drive to the external multiplier
//   mul_p                 - product from the multiplier
//   res_valid/res_ready   - result handshake; res_p raw product, res_id issuing requester
//   busy                  - not in IDLE
module mul_seq_arb
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned IDW         = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  output logic                mul_en,
  input  logic [PW-1:0]       mul_p,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PW-1:0]       res_p,
  output logic [IDW-1:0]      res_id,
  output logic                busy
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0] opa_q, opa_d;
  logic [OPW-1:0] opb_q, opb_d;
  logic [IDW-1:0] id_q, id_d;
  logic [PW-1:0]  res_p_q, res_p_d;

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            handshake;

  // Requests are only visible to the arbiter in IDLE and never during the reset cycle.
  assign arb_req   = ((state_q == IDLE) && !rst) ? req_valid : '0;
  assign handshake = |(req_valid & grant);

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .advance  (handshake),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    id_d    = id_q;
    res_p_d = res_p_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              opa_d = req_a[i*OPW +: OPW];
              opb_d = req_b[i*OPW +: OPW];
            end
          end
          id_d    = grant_id;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        res_p_d = mul_p;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      id_q    <= '0;
      res_p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      id_q    <= id_d;
      res_p_q <= res_p_d;
    end
  end

  // Operand registers only load in IDLE, so mul_a/mul_b cannot move while mul_en is high.
  assign req_ready = grant;
  assign mul_a     = opa_q;
  assign mul_b     = opb_q;
  assign mul_en    = (state_q == HOLD) || (state_q == SAMPLE);
  assign res_valid = (state_q == DONE);
  assign res_p     = res_p_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq_arb.sv
module tb_mul_seq_arb;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [19:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [4:0]  mul_a, mul_b;
  logic        mul_en;
  logic [8:0]  mul_p;
  logic        res_valid, res_ready;
  logic [8:0]  res_p;
  logic [1:0]  res_id;
  logic        busy;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int rr_last = 3;
  int tb_pa, tb_pb;

  mul_seq_arb #(
    .NREQ        (4),
    .HOLD_CYCLES (6),
    .IDW         (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: combinational signed product of whatever is on the operand ports.
  always_comb begin
    tb_pa = int'($signed(mul_a));
    tb_pb = int'($signed(mul_b));
    mul_p = 9'(tb_pa * tb_pb);
  end

  function automatic logic [8:0] ref_mul(input logic [4:0] a, input logic [4:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 9'(sa * sb);
  endfunction

  function automatic int ref_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_slot(input int s, input logic [4:0] a, input logic [4:0] b);
    req_a[s*5 +: 5] = a;
    req_b[s*5 +: 5] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_last = 3;
  endtask

  // Steps cycles until a handshake is seen; returns at the start of cycle h+1.
  task automatic wait_grant(output int gid, output int hcyc, output logic [3:0] rdy,
                            output bit ok);
    ok = 1'b0; gid = -1; hcyc = 0; rdy = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        ok   = 1'b1;
        rdy  = req_ready;
        hcyc = cyc;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
  endtask

  // Called at start of cycle h+1; returns at the negedge where res_valid is first seen.
  task automatic wait_result(input bit scramble, output int lat, output bit ok, output bit held,
                             output logic [4:0] a0, output logic [4:0] b0);
    ok = 1'b0; held = 1'b1; lat = 0; a0 = '0; b0 = '0;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        req_valid = 4'($urandom);
        req_a     = 20'($urandom);
        req_b     = 20'($urandom);
      end
      @(negedge clk);
      if (res_valid) begin
        ok  = 1'b1;
        lat = k;
        break;
      end
      if (k == 1) begin
        a0 = mul_a;
        b0 = mul_b;
      end
      if (mul_a !== a0 || mul_b !== b0 || mul_en !== 1'b1 || req_ready !== 4'b0 ||
          busy !== 1'b1) held = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    req_a = 20'($urandom);
    req_b = 20'($urandom);
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_cycle_ready: got %b expected 0000", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    rr_last = 3;
    @(negedge clk);
    checks++;
    if ({busy, res_valid, mul_en, req_ready} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b res_valid=%b mul_en=%b req_ready=%b expected all 0",
                         busy, res_valid, mul_en, req_ready);
    end
    checks++;
    if ({res_p, res_id} !== 11'b0) begin
      errors++; $display("FAIL reset_result: got res_p=%h res_id=%0d expected 0/0", res_p, res_id);
    end
    checks++;
    if ({mul_a, mul_b} !== 10'b0) begin
      errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", mul_a, mul_b);
    end
    @(posedge clk); #1;
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_pick: got %b expected 0001", req_ready);
    end
    req_valid = '0;  // withdraw before the edge so no handshake happens
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int gid, h, lat;
    logic [3:0] rdy;
    logic [4:0] a0, b0;
    bit ok, held;
    req_valid = 4'b0100;
    set_slot(2, 5'b11101, 5'b00111);  // -3, 7
    res_ready = 1'b1;
    wait_grant(gid, h, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0100) begin
      errors++; $display("FAIL single_grant: got %b expected 0100", rdy);
    end
    rr_last = 2;
    req_valid = '0;
    wait_result(1'b0, lat, ok, held, a0, b0);
    checks++;
    if (!ok || lat != 8) begin
      errors++; $display("FAIL single_latency: got %0d expected 8", lat);
    end
    checks++;
    if (!held || a0 !== 5'b11101 || b0 !== 5'b00111) begin
      errors++; $display("FAIL single_operands: got %h/%h held=%b expected 1d/07 held=1", a0, b0, held);
    end
    checks++;
    if (res_p !== 9'h1EB) begin
      errors++; $display("FAIL single_product: got %h expected 1eb", res_p);
    end
    checks++;
    if (res_id !== 2'd2) begin
      errors++; $display("FAIL single_id: got %0d expected 2", res_id);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got busy=%b res_valid=%b expected 0/0", busy, res_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int gid, h, lat, exp_id;
    logic [3:0] rdy;
    logic [4:0] a0, b0;
    bit ok, held;
    req_valid = 4'b0001;
    set_slot(0, 5'h10, 5'h0F);  // -16, 15
    exp_id = ref_pick(4'b0001, rr_last);
    wait_grant(gid, h, rdy, ok);
    checks++;
    if (!ok || gid != exp_id) begin
      errors++; $display("FAIL hold_grant: got %0d expected %0d", gid, exp_id);
    end
    rr_last = exp_id;
    wait_result(1'b1, lat, ok, held, a0, b0);
    checks++;
    if (!ok || lat != 8 || !held || a0 !== 5'h10 || b0 !== 5'h0F) begin
      errors++; $display("FAIL hold_stable: got lat=%0d held=%b ops=%h/%h expected 8/1/10/0f",
                         lat, held, a0, b0);
    end
    checks++;
    if (res_p !== 9'h110) begin
      errors++; $display("FAIL hold_product: got %h expected 110", res_p);
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int gid, h, lat, prev, exp_id;
    logic [3:0] rdy;
    logic [4:0] a0, b0;
    logic [8:0] exp_p;
    bit ok, held;
    apply_reset();
    req_valid = 4'hF;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      req_a = 20'($urandom);
      req_b = 20'($urandom);
      exp_id = ref_pick(4'hF, rr_last);
      exp_p  = ref_mul(req_a[exp_id*5 +: 5], req_b[exp_id*5 +: 5]);
      wait_grant(gid, h, rdy, ok);
      checks++;
      if (!ok || gid != exp_id || exp_id != i % NREQ || rdy !== 4'(1 << exp_id)) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b expected id %0d", i, rdy, i % NREQ);
      end
      if (i > 0) begin
        checks++;
        if (h - prev != 9) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 9", i, h - prev);
        end
      end
      prev = h;
      rr_last = exp_id;
      wait_result(1'b0, lat, ok, held, a0, b0);
      checks++;
      if (!ok || lat != 8 || res_p !== exp_p || res_id !== 2'(exp_id)) begin
        errors++; $display("FAIL rr_result[%0d]: got lat=%0d p=%h id=%0d expected 8/%h/%0d",
                           i, lat, res_p, res_id, exp_p, exp_id);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int gid, h, lat, exp_id;
    logic [3:0] rdy;
    logic [4:0] a0, b0;
    bit ok, held, stable;
    req_valid = 4'b0010;
    set_slot(1, 5'd15, 5'd15);
    res_ready = 1'b0;
    exp_id = ref_pick(4'b0010, rr_last);
    wait_grant(gid, h, rdy, ok);
    checks++;
    if (!ok || gid != exp_id) begin
      errors++; $display("FAIL bp_grant: got %0d expected %0d", gid, exp_id);
    end
    rr_last = exp_id;
    req_valid = 4'hF;
    wait_result(1'b0, lat, ok, held, a0, b0);
    checks++;
    if (!ok || lat != 8 || res_p !== 9'd225) begin
      errors++; $display("FAIL bp_product: got lat=%0d p=%0d expected 8/225", lat, res_p);
    end
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_p !== 9'd225 || res_id !== 2'(exp_id) ||
          req_ready !== 4'b0 || busy !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_stall: got res_valid=%b p=%0d ready=%b expected 1/225/0000",
                         res_valid, res_p, req_ready);
    end
    res_ready = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got busy=%b res_valid=%b expected 0/0", busy, res_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int gid, h, lat, exp_id;
    logic [3:0] rdy;
    logic [4:0] a0, b0;
    logic [8:0] exp_p;
    bit ok, held, quiet;
    req_valid = 4'b1000;
    set_slot(3, 5'd7, 5'd5);
    exp_id = ref_pick(4'b1000, rr_last);
    wait_grant(gid, h, rdy, ok);
    checks++;
    if (!ok || gid != exp_id) begin
      errors++; $display("FAIL rstmid_grant: got %0d expected %0d", gid, exp_id);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;  // cycle h+4
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL rstmid_no_grant: got %b expected 0000", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    rr_last = 3;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || mul_en !== 1'b0 || busy !== 1'b0 ||
          {mul_a, mul_b, res_p, res_id} !== 21'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL rstmid_discard: got res_valid=%b mul_en=%b busy=%b p=%h expected idle reset state",
                         res_valid, mul_en, busy, res_p);
    end
    req_valid = 4'hF;
    set_slot(0, 5'($urandom), 5'($urandom));
    exp_id = ref_pick(4'hF, rr_last);
    exp_p  = ref_mul(req_a[4:0], req_b[4:0]);
    wait_grant(gid, h, rdy, ok);
    checks++;
    if (!ok || gid != exp_id || exp_id != 0) begin
      errors++; $display("FAIL rstmid_first_grant: got %0d expected 0", gid);
    end
    rr_last = exp_id;
    req_valid = '0;
    wait_result(1'b0, lat, ok, held, a0, b0);
    checks++;
    if (!ok || lat != 8 || res_p !== exp_p) begin
      errors++; $display("FAIL rstmid_result: got lat=%0d p=%h expected 8/%h", lat, res_p, exp_p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_edge();
    logic [4:0] ea [2] = '{5'd0, 5'h1F};
    logic [4:0] eb [2] = '{5'h10, 5'h1F};
    logic [8:0] ep [2] = '{9'd0, 9'd1};
    int gid, h, lat, s;
    logic [3:0] rdy;
    logic [4:0] a0, b0;
    bit ok, held;
    for (int i = 0; i < 2; i++) begin
      s = int'($urandom_range(0, 3));
      req_valid = 4'(1 << s);
      set_slot(s, ea[i], eb[i]);
      wait_grant(gid, h, rdy, ok);
      checks++;
      if (!ok || gid != s) begin
        errors++; $display("FAIL edge_grant[%0d]: got %0d expected %0d", i, gid, s);
      end
      rr_last = s;
      req_valid = '0;
      wait_result(1'b0, lat, ok, held, a0, b0);
      checks++;
      if (!ok || res_p !== ep[i] || res_id !== 2'(s)) begin
        errors++; $display("FAIL edge_product[%0d]: got p=%h id=%0d expected %h/%0d",
                           i, res_p, res_id, ep[i], s);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int gid, h, lat, exp_id, bp;
    logic [3:0] rdy, v;
    logic [4:0] a0, b0;
    logic [8:0] exp_p;
    bit ok, held, stable;
    for (int i = 0; i < 12; i++) begin
      v = 4'($urandom_range(1, 15));
      req_valid = v;
      req_a = 20'($urandom);
      req_b = 20'($urandom);
      bp = int'($urandom_range(0, 3));
      res_ready = (bp == 0);
      exp_id = ref_pick(v, rr_last);
      exp_p  = ref_mul(req_a[exp_id*5 +: 5], req_b[exp_id*5 +: 5]);
      wait_grant(gid, h, rdy, ok);
      checks++;
      if (!ok || gid != exp_id) begin
        errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d (valid=%b)", i, gid, exp_id, v);
      end
      rr_last = exp_id;
      wait_result(1'($urandom_range(0, 1)), lat, ok, held, a0, b0);
      checks++;
      if (!ok || lat != 8 || !held || res_p !== exp_p || res_id !== 2'(exp_id)) begin
        errors++; $display("FAIL rand_result[%0d]: got lat=%0d held=%b p=%h id=%0d expected 8/1/%h/%0d",
                           i, lat, held, res_p, res_id, exp_p, exp_id);
      end
      stable = 1'b1;
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (res_valid !== 1'b1 || res_p !== exp_p || req_ready !== 4'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
        errors++; $display("FAIL rand_backpressure[%0d]: got res_valid=%b p=%h expected 1/%h",
                           i, res_valid, res_p, exp_p);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_hold();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
